// File: rtl/pc_pkg.sv
// Shared select codes and address width for the program-counter block.
package pc_pkg;

  localparam int unsigned PC_W = 10;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_XFER = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b10;
  localparam logic [1:0] PC_JR   = 2'b11;

  localparam logic [1:0] PC_BEQZ = 2'b00;
  localparam logic [1:0] PC_JREL = 2'b01;
  localparam logic [1:0] PC_JABS = 2'b10;
  localparam logic [1:0] PC_BNEZ = 2'b11;

endpackage

// File: rtl/pc_unit_if.sv
// Control-unit / instruction-memory side signals of the program counter.
interface pc_unit_if;
  import pc_pkg::*;

  logic [1:0]      PC_MUX;
  logic [1:0]      PC_DIRECT_CH;
  logic [31:0]     PC_rd;
  logic [31:0]     RESULT;
  logic [15:0]     instr;
  logic [PC_W-1:0] PC;
  logic [PC_W-1:0] PC_2;

  modport master (
    output PC_MUX, PC_DIRECT_CH, PC_rd, RESULT, instr,
    input  PC, PC_2
  );

  modport slave (
    input  PC_MUX, PC_DIRECT_CH, PC_rd, RESULT, instr,
    output PC, PC_2
  );
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential, transfer, hold, jump-register.
// PC_BNZ_EN enables the branch-if-nonzero transfer type.
module pc_next_mux
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [1:0]      pc_mux,
  input  logic [1:0]      direct_ch,
  input  logic [31:0]     pc_rd,
  input  logic [31:0]     result,
  input  logic [15:0]     instr,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] imm;
  logic [PC_W-1:0] rel;
  logic            res_zero;
  logic            unused_bits;

  // Sign-extending instr[9:0] then shifting left by one and truncating to
  // 10 bits leaves only instr[8:0]; the sign bit never reaches the result.
  always_comb begin
    seq      = pc + PC_W'(2);
    off      = {instr[8:0], 1'b0};
    imm      = {instr[8:0], 1'b0};
    rel      = seq + off;
    res_zero = (result == '0);
  end

  always_comb begin
    next_pc = seq;
    case (pc_mux)
      PC_SEQ:  next_pc = seq;
      PC_XFER: begin
        case (direct_ch)
          PC_BEQZ: next_pc = res_zero ? rel : seq;
          PC_JREL: next_pc = rel;
          PC_JABS: next_pc = imm;
`ifdef PC_BNZ_EN
          PC_BNEZ: next_pc = res_zero ? seq : rel;
`else
          default: next_pc = seq;
`endif
        endcase
      end
      PC_HOLD: next_pc = pc;
      PC_JR:   next_pc = {pc_rd[PC_W-1:1], 1'b0};
      default: next_pc = seq;
    endcase
  end

  assign unused_bits = ^{instr[15:9], pc_rd[31:PC_W], pc_rd[0]};

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with asynchronous active-low reset and PC+2 link output.
// Optional macro: PC_BNZ_EN (branch-if-nonzero on PC_DIRECT_CH=11).
module pc_unit
  import pc_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] next_pc;

  pc_next_mux u_next_mux (
    .pc        (pc_q),
    .pc_mux    (bus.PC_MUX),
    .direct_ch (bus.PC_DIRECT_CH),
    .pc_rd     (bus.PC_rd),
    .result    (bus.RESULT),
    .instr     (bus.instr),
    .next_pc   (next_pc)
  );

  always_comb begin
    pc_d = next_pc & ~PC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  always_comb begin
    bus.PC   = pc_q;
    bus.PC_2 = pc_q + PC_W'(2);
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected PCs queued at drive time, checked after each edge.
module tb_pc_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic reset;

  pc_unit_if bus ();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned     checks = 0;
  int unsigned     errors = 0;
  logic [PC_W-1:0] exp_q[$];

  task automatic check_pc(input string tag, input logic [PC_W-1:0] exp_pc);
    logic [PC_W-1:0] exp_p2;
    exp_p2 = exp_pc + 10'd2;
    checks++;
    assert (bus.PC === exp_pc) else begin
      errors++;
      $error("FAIL %s PC: got 0x%03h expected 0x%03h", tag, bus.PC, exp_pc);
    end
    checks++;
    assert (bus.PC_2 === exp_p2) else begin
      errors++;
      $error("FAIL %s PC_2: got 0x%03h expected 0x%03h", tag, bus.PC_2, exp_p2);
    end
  endtask

  task automatic drive(input logic [1:0] mux, input logic [1:0] ch,
                       input logic [31:0] rd, input logic [31:0] res,
                       input logic [15:0] ins);
    bus.PC_MUX       = mux;
    bus.PC_DIRECT_CH = ch;
    bus.PC_rd        = rd;
    bus.RESULT       = res;
    bus.instr        = ins;
  endtask

  task automatic step(input string tag, input logic [1:0] mux, input logic [1:0] ch,
                      input logic [31:0] rd, input logic [31:0] res,
                      input logic [15:0] ins, input logic [PC_W-1:0] exp_pc);
    drive(mux, ch, rd, res, ins);
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    check_pc(tag, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(PC_SEQ, PC_BEQZ, 32'h0, 32'h0, 16'h0);

    // Reset value visible before any clock edge.
    #1;
    exp_q.push_back(10'h000);
    check_pc("reset_noclk", exp_q.pop_front());
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(10'h000);
    check_pc("reset_held", exp_q.pop_front());
    reset = 1'b1;

    step("seq1",  PC_SEQ,  PC_BEQZ, 32'h0, 32'h0, 16'h0, 10'h002);
    step("seq2",  PC_SEQ,  PC_BEQZ, 32'h0, 32'h0, 16'h0, 10'h004);
    step("hold1", PC_HOLD, PC_JREL, 32'h0, 32'h0, 16'h0005, 10'h004);
    step("hold2", PC_HOLD, PC_JREL, 32'h0, 32'h0, 16'h0005, 10'h004);
    step("hold3", PC_HOLD, PC_JREL, 32'h0, 32'h0, 16'h0005, 10'h004);

    step("jrel_self", PC_XFER, PC_JREL, 32'h0, 32'h0, 16'h0BFF, 10'h004);
    step("jrel_fwd",  PC_XFER, PC_JREL, 32'h0, 32'h0, 16'h0005, 10'h010);

    step("jr_to4a",   PC_JR,   PC_BEQZ, 32'h0000_0004, 32'h0, 16'h0, 10'h004);
    step("beqz_nt",   PC_XFER, PC_BEQZ, 32'h0, 32'h0000_FFFF, 16'h0BFF, 10'h006);
    step("jr_to4b",   PC_JR,   PC_BEQZ, 32'h0000_0004, 32'h0, 16'h0, 10'h004);
    step("beqz_t",    PC_XFER, PC_BEQZ, 32'h0, 32'h0, 16'h0BFF, 10'h004);
    step("beqz_msb",  PC_XFER, PC_BEQZ, 32'h0, 32'h8000_0000, 16'h0BFF, 10'h006);
    step("jr_to4c",   PC_JR,   PC_BEQZ, 32'h0000_0004, 32'h0, 16'h0, 10'h004);
`ifdef PC_BNZ_EN
    step("bnez_t",    PC_XFER, PC_BNEZ, 32'h0, 32'h0000_FFFF, 16'h0BFF, 10'h004);
    step("bnez_nt",   PC_XFER, PC_BNEZ, 32'h0, 32'h0, 16'h0BFF, 10'h006);
`else
    step("bnez_off",  PC_XFER, PC_BNEZ, 32'h0, 32'h0000_FFFF, 16'h0BFF, 10'h006);
`endif

    step("jabs",      PC_XFER, PC_JABS, 32'h0, 32'h0, 16'h0BFF, 10'h3FE);
    step("wrap",      PC_SEQ,  PC_BEQZ, 32'h0, 32'h0, 16'h0, 10'h000);
    step("jr_odd",    PC_JR,   PC_BEQZ, 32'h0001_2345, 32'h0, 16'h0, 10'h344);

    // Asynchronous reset mid-cycle, then reset must override hold.
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(10'h000);
    check_pc("reset_async", exp_q.pop_front());
    step("reset_hold", PC_HOLD, PC_BEQZ, 32'h0, 32'h0, 16'h0, 10'h000);
    reset = 1'b1;
    step("post_reset", PC_SEQ,  PC_BEQZ, 32'h0, 32'h0, 16'h0, 10'h002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
